// File: rtl/vga_grid_capture_pkg.sv
// Shared VGA timing defaults, grid geometry and capture FSM encoding.
// Included by both the grid generator and the capture block so their timings agree.
package vga_grid_capture_pkg;

    localparam int unsigned DefClkDiv = 2;
    localparam int unsigned DefHVis   = 640;
    localparam int unsigned DefHFp    = 16;
    localparam int unsigned DefHSync  = 96;
    localparam int unsigned DefHBp    = 48;
    localparam int unsigned DefVVis   = 480;
    localparam int unsigned DefVFp    = 10;
    localparam int unsigned DefVSync  = 2;
    localparam int unsigned DefVBp    = 33;

    localparam int unsigned GridCols = 4;
    localparam int unsigned GridRows = 4;

    localparam int unsigned HclkW = 12;
    localparam int unsigned LineW = 10;
    localparam int unsigned WcntW = 5;

    typedef enum logic [1:0] {
        StSearch,
        StTrack,
        StLocked
    } cap_state_e;

endpackage

// File: rtl/vga_sync_tracker.sv
// Registers the VGA inputs, finds sync falling edges and keeps the clock/line counters.
// Flags timing violations while check is high.
module vga_sync_tracker
    import vga_grid_capture_pkg::*;
#(
    parameter int unsigned CLK_DIV = DefClkDiv,
    parameter int unsigned H_TOT   = 800,
    parameter int unsigned V_TOT   = 525
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             check,
    input  logic             hsync_n,
    input  logic             vsync_n,
    input  logic             r,
    input  logic             g,
    input  logic             b,
    output logic [2:0]       rgb,
    output logic             hfall,
    output logic             vfall,
    output logic [HclkW-1:0] hclk,
    output logic [LineW-1:0] line,
    output logic             err
);

    localparam logic [HclkW-1:0] HclkLine = HclkW'(H_TOT * CLK_DIV - 1);
    localparam logic [HclkW-1:0] HclkMax  = HclkW'(2 * H_TOT * CLK_DIV - 1);
    localparam logic [LineW-1:0] LineLast = LineW'(V_TOT - 1);

    logic             hs_q, hs_prev_q, vs_q, vs_prev_q;
    logic [2:0]       rgb_q;
    logic [HclkW-1:0] hclk_q, hclk_d;
    logic [LineW-1:0] line_q, line_d;

    // Syncs reset to idle-high so reset release cannot fake an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q      <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_q      <= 1'b1;
            vs_prev_q <= 1'b1;
            rgb_q     <= '0;
            hclk_q    <= '0;
            line_q    <= '0;
        end else begin
            hs_q      <= hsync_n;
            hs_prev_q <= hs_q;
            vs_q      <= vsync_n;
            vs_prev_q <= vs_q;
            rgb_q     <= {r, g, b};
            hclk_q    <= hclk_d;
            line_q    <= line_d;
        end
    end

    assign hfall = hs_prev_q & ~hs_q;
    assign vfall = vs_prev_q & ~vs_q;

    always_comb begin
        hclk_d = hclk_q;
        if (hfall) begin
            hclk_d = '0;
        end else if (hclk_q != HclkMax) begin
            hclk_d = hclk_q + HclkW'(1);
        end
        line_d = line_q;
        if (vfall) begin
            line_d = '0;
        end else if (hfall && line_q != '1) begin
            line_d = line_q + LineW'(1);
        end
    end

    assign err = check & ((hfall & (hclk_q != HclkLine)) |
                          (~hfall & (hclk_q == HclkMax)) |
                          (vfall & (line_q != LineLast)));

    assign rgb  = rgb_q;
    assign hclk = hclk_q;
    assign line = line_q;

endmodule

// File: rtl/vga_grid_capture.sv
// Reconstructs the 4x4 grid of cell colours from a VGA stream by sampling each cell centre
// once timing is locked, and replays it as register-bank writes.
module vga_grid_capture
    import vga_grid_capture_pkg::*;
#(
    parameter int unsigned CLK_DIV = DefClkDiv,
    parameter int unsigned H_VIS   = DefHVis,
    parameter int unsigned H_FP    = DefHFp,
    parameter int unsigned H_SYNC  = DefHSync,
    parameter int unsigned H_BP    = DefHBp,
    parameter int unsigned V_VIS   = DefVVis,
    parameter int unsigned V_FP    = DefVFp,
    parameter int unsigned V_SYNC  = DefVSync,
    parameter int unsigned V_BP    = DefVBp
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       VGA_Hsync_n,
    input  logic       VGA_Vsync_n,
    input  logic       VGA_R,
    input  logic       VGA_G,
    input  logic       VGA_B,
    output logic [3:0] addrW,
    output logic [2:0] datW,
    output logic       RegWrite,
    output logic       locked,
    output logic       frame_done,
    output logic       sync_err
);

    localparam int unsigned HTot  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTot  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned CellW = H_VIS / GridCols;
    localparam int unsigned CellH = V_VIS / GridRows;
    localparam logic [WcntW-1:0] WcntFull = WcntW'(GridCols * GridRows);

    cap_state_e       state_q, state_d;
    logic             hfall, vfall, err, check;
    logic [HclkW-1:0] hclk;
    logic [LineW-1:0] line;
    logic [2:0]       rgb;
    logic             row_hit, col_hit;
    logic [1:0]       row_idx, col_idx;
    logic             wr_en, done_d;
    logic [WcntW-1:0] wcnt_q, wcnt_d;
    logic [3:0]       addr_q;
    logic [2:0]       dat_q;
    logic             wr_q, done_q, err_q;

    assign check = (state_q != StSearch);

    vga_sync_tracker #(
        .CLK_DIV (CLK_DIV),
        .H_TOT   (HTot),
        .V_TOT   (VTot)
    ) u_tracker (
        .clk     (clk),
        .rst     (rst),
        .check   (check),
        .hsync_n (VGA_Hsync_n),
        .vsync_n (VGA_Vsync_n),
        .r       (VGA_R),
        .g       (VGA_G),
        .b       (VGA_B),
        .rgb     (rgb),
        .hfall   (hfall),
        .vfall   (vfall),
        .hclk    (hclk),
        .line    (line),
        .err     (err)
    );

    // Cell-centre decode: row from the line count, column from the clock count.
    always_comb begin
        row_hit = 1'b0;
        row_idx = '0;
        for (int unsigned r = 0; r < GridRows; r++) begin
            if (line == LineW'(V_SYNC + V_BP + CellH / 2 + CellH * r)) begin
                row_hit = 1'b1;
                row_idx = 2'(r);
            end
        end
        col_hit = 1'b0;
        col_idx = '0;
        for (int unsigned c = 0; c < GridCols; c++) begin
            if (hclk == HclkW'((H_SYNC + H_BP + CellW / 2 + CellW * c) * CLK_DIV)) begin
                col_hit = 1'b1;
                col_idx = 2'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StSearch;
        end else begin
            state_q <= state_d;
        end
    end

    // Errors are only raised outside SEARCH, so an erroring Vsync fall never starts TRACK.
    always_comb begin
        state_d = state_q;
        if (err) begin
            state_d = StSearch;
        end else begin
            case (state_q)
                StSearch: if (vfall) state_d = StTrack;
                StTrack:  if (vfall) state_d = StLocked;
                StLocked: state_d = StLocked;
                default:  state_d = StSearch;
            endcase
        end
    end

    always_comb begin
        wr_en  = (state_q == StLocked) && row_hit && col_hit && !hfall && !err &&
                 (wcnt_q != WcntFull);
        done_d = (state_q == StLocked) && vfall && !err && (wcnt_q == WcntFull);
        wcnt_d = wcnt_q;
        if (vfall || state_d != StLocked) begin
            wcnt_d = '0;
        end else if (wr_en) begin
            wcnt_d = wcnt_q + WcntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
            addr_q <= '0;
            dat_q  <= '0;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            wr_q   <= wr_en;
            done_q <= done_d;
            err_q  <= err;
            if (wr_en) begin
                addr_q <= {row_idx, col_idx};
                dat_q  <= rgb;
            end
        end
    end

    assign addrW      = addr_q;
    assign datW       = dat_q;
    assign RegWrite   = wr_q;
    assign locked     = (state_q == StLocked);
    assign frame_done = done_q;
    assign sync_err   = err_q;

endmodule

// File: tb/tb_vga_grid_capture.sv
// Directed bench for vga_grid_capture on a shrunken 16x8 mode (48 clocks/line, 12 lines/frame).
// A pixel-level stream model drives the sync/RGB lines; outputs are sampled 1 time unit after clk.
module tb_vga_grid_capture;

    localparam int LineClks   = 48;
    localparam int FrameLines = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hs_n, vs_n, r, g, b;
    logic [3:0] addrW;
    logic [2:0] datW;
    logic       RegWrite, locked, frame_done, sync_err;

    always #5 clk = ~clk;

    vga_grid_capture #(
        .CLK_DIV (2),
        .H_VIS   (16),
        .H_FP    (2),
        .H_SYNC  (4),
        .H_BP    (2),
        .V_VIS   (8),
        .V_FP    (1),
        .V_SYNC  (1),
        .V_BP    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .VGA_Hsync_n (hs_n),
        .VGA_Vsync_n (vs_n),
        .VGA_R       (r),
        .VGA_G       (g),
        .VGA_B       (b),
        .addrW       (addrW),
        .datW        (datW),
        .RegWrite    (RegWrite),
        .locked      (locked),
        .frame_done  (frame_done),
        .sync_err    (sync_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Stream position of the most recently driven clock.
    int gx = 0;
    int gy = 5;
    bit hs_stuck = 1'b0;
    bit short_en = 1'b0;
    int short_gy = 0;
    logic [2:0] cell_col [16];

    int         wr_n;
    logic [3:0] wr_addr [32];
    logic [2:0] wr_dat  [32];
    int         wr_gx   [32];
    int         wr_gy   [32];
    int         fd_n, fd_gx, fd_gy;
    int         se_n, se_gx, se_gy;

    task automatic drive();
        int px, py;
        logic [2:0] col;
        hs_n = hs_stuck ? 1'b1 : (gx >= 8);
        vs_n = (gy >= 1);
        px = gx / 2 - 6;
        py = gy - 3;
        col = 3'b000;
        if (px >= 0 && px < 16 && py >= 0 && py < 8) col = cell_col[(py / 2) * 4 + px / 4];
        {r, g, b} = col;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (RegWrite === 1'b1) begin
            if (wr_n < 32) begin
                wr_addr[wr_n] = addrW;
                wr_dat[wr_n]  = datW;
                wr_gx[wr_n]   = gx;
                wr_gy[wr_n]   = gy;
            end
            wr_n++;
        end
        if (frame_done === 1'b1) begin
            fd_n++; fd_gx = gx; fd_gy = gy;
        end
        if (sync_err === 1'b1) begin
            se_n++; se_gx = gx; se_gy = gy;
        end
        gx++;
        if (gx >= ((short_en && gy == short_gy) ? LineClks - 2 : LineClks)) begin
            if (short_en && gy == short_gy) short_en = 1'b0;
            gx = 0;
            gy = (gy + 1) % FrameLines;
        end
        drive();
    endtask

    task automatic clear_logs();
        wr_n = 0; fd_n = 0; se_n = 0;
        fd_gx = -1; fd_gy = -1; se_gx = -1; se_gy = -1;
    endtask

    task automatic run_to(input int ty, input int tx);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(gy == ty && gx == tx) && n < 2000);
        if (!(gy == ty && gx == tx)) begin
            n_cmp++; n_err++;
            $display("FAIL run_to_timeout: got gy=%0d gx=%0d, required gy=%0d gx=%0d",
                     gy, gx, ty, tx);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if ({addrW, datW, RegWrite, locked, frame_done, sync_err} !== 11'b0) begin
                n_err++;
                $display("FAIL reset_outputs cycle %0d: got %b, required 0", i,
                         {addrW, datW, RegWrite, locked, frame_done, sync_err});
            end
        end
        rst = 1'b0;
        step();
        chk_bit("reset_release_no_write", RegWrite, 1'b0);
        chk_bit("reset_release_unlocked", locked, 1'b0);
    endtask

    task automatic test_nominal();
        for (int k = 0; k < 16; k++) cell_col[k] = 3'b101;
        clear_logs();
        run_to(0, 0);
        step(); step();
        chk_bit("track_not_locked", locked, 1'b0);
        run_to(0, 0);
        chk_int("no_write_before_lock", wr_n, 0);
        step();
        chk_bit("lock_not_early", locked, 1'b0);
        step();
        chk_bit("lock_rise", locked, 1'b1);
        clear_logs();
        run_to(0, 0);
        step(); step();
        chk_int("nominal_write_count", wr_n, 16);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (wr_addr[i] !== 4'(i) || wr_dat[i] !== 3'b101) begin
                n_err++;
                $display("FAIL nominal_write %0d: got addr=%0d dat=%0d, required addr=%0d dat=5",
                         i, wr_addr[i], wr_dat[i], i);
            end
        end
        chk_int("nominal_frame_done_count", fd_n, 1);
        chk_int("nominal_frame_done_line", fd_gy, 0);
        chk_int("nominal_frame_done_clk", fd_gx, 1);
        chk_int("nominal_no_sync_err", se_n, 0);
    endtask

    task automatic test_cell_index();
        for (int k = 0; k < 16; k++) cell_col[k] = 3'(k);
        clear_logs();
        run_to(0, 0);
        step(); step();
        chk_int("index_write_count", wr_n, 16);
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (wr_addr[k] !== 4'(k) || wr_dat[k] !== 3'(k % 8) ||
                wr_gx[k] != 18 + 8 * (k % 4) || wr_gy[k] != 4 + 2 * (k / 4)) begin
                n_err++;
                $display("FAIL index_write %0d: got addr=%0d dat=%0d at %0d/%0d, required addr=%0d dat=%0d at %0d/%0d",
                         k, wr_addr[k], wr_dat[k], wr_gy[k], wr_gx[k], k, k % 8,
                         4 + 2 * (k / 4), 18 + 8 * (k % 4));
            end
        end
        chk_int("index_frame_done_count", fd_n, 1);
    endtask

    task automatic test_short_line();
        clear_logs();
        short_gy = 2;
        short_en = 1'b1;
        run_to(3, 0);
        step(); step();
        chk_bit("short_sync_err", sync_err, 1'b1);
        chk_bit("short_unlocked", locked, 1'b0);
        step();
        chk_bit("short_sync_err_one_pulse", sync_err, 1'b0);
        clear_logs();
        run_to(0, 0);
        step(); step();
        chk_bit("short_retrack_unlocked", locked, 1'b0);
        run_to(0, 0);
        chk_int("short_no_writes_relocking", wr_n, 0);
        step(); step();
        chk_bit("short_relocked", locked, 1'b1);
        clear_logs();
        run_to(0, 0);
        step(); step();
        chk_int("short_relock_writes", wr_n, 16);
        chk_int("short_relock_frame_done", fd_n, 1);
    endtask

    task automatic test_hsync_stuck();
        int n;
        clear_logs();
        run_to(5, 8);
        hs_stuck = 1'b1;
        n = 0;
        while (se_n == 0 && n < 300) begin
            step();
            n++;
        end
        chk_int("stuck_sync_err_count", se_n, 1);
        chk_int("stuck_sync_err_line", se_gy, 7);
        chk_int("stuck_sync_err_clk", se_gx, 1);
        chk_bit("stuck_unlocked", locked, 1'b0);
        for (int i = 0; i < 150; i++) step();
        chk_int("stuck_no_repeat_err", se_n, 1);
        chk_int("stuck_only_row0_written", wr_n, 4);
        run_to(11, 20);
        hs_stuck = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int n;
        run_to(0, 0);
        step(); step();
        chk_bit("midrst_track_unlocked", locked, 1'b0);
        run_to(0, 0);
        step(); step();
        chk_bit("midrst_locked", locked, 1'b1);
        clear_logs();
        n = 0;
        while (wr_n < 8 && n < 1000) begin
            step();
            n++;
        end
        chk_int("midrst_eighth_write_addr", int'(wr_addr[7]), 7);
        rst = 1'b1;
        step();
        n_cmp++;
        if ({addrW, datW, RegWrite, locked, frame_done, sync_err} !== 11'b0) begin
            n_err++;
            $display("FAIL midrst_outputs: got %b, required 0",
                     {addrW, datW, RegWrite, locked, frame_done, sync_err});
        end
        step(); step();
        rst = 1'b0;
        run_to(0, 0);
        step(); step(); step(); step();
        chk_int("midrst_no_more_writes", wr_n, 8);
        chk_int("midrst_no_frame_done", fd_n, 0);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) cell_col[k] = 3'b000;
        clear_logs();
        drive();
        test_reset();
        test_nominal();
        test_cell_index();
        test_short_line();
        test_hsync_stuck();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
